// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, states, condition codes and IR field positions
package cu_pkg;

   typedef enum logic [2:0] {
      OP_ALU_R = 3'd0,
      OP_ALU_I = 3'd1,
      OP_LOAD  = 3'd2,
      OP_STORE = 3'd3,
      OP_B     = 3'd4,
      OP_BCOND = 3'd5,
      OP_RSVD  = 3'd6,
      OP_HALT  = 3'd7
   } op_e;

   // Sequencer state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_FETCH = 2'd0;
   localparam state_t ST_EXEC  = 2'd1;
   localparam state_t ST_MEM   = 2'd2;
   localparam state_t ST_HALT  = 2'd3;

   localparam logic [3:0] CC_EQ = 4'd0;
   localparam logic [3:0] CC_NE = 4'd1;
   localparam logic [3:0] CC_LT = 4'd2;
   localparam logic [3:0] CC_GE = 4'd3;
   localparam logic [3:0] CC_CS = 4'd4;
   localparam logic [3:0] CC_CC = 4'd5;

   localparam logic [4:0] FS_ADD = 5'b01000;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 29;
   localparam int FS_MSB  = 28;
   localparam int FS_LSB  = 24;
   localparam int DA_MSB  = 23;
   localparam int DA_LSB  = 19;
   localparam int SA_MSB  = 18;
   localparam int SA_LSB  = 14;
   localparam int SB_MSB  = 13;
   localparam int SB_LSB  = 9;
   localparam int IMM_MSB = 13;
   localparam int IMM_LSB = 0;
   localparam int CC_MSB  = 22;
   localparam int CC_LSB  = 19;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   function automatic logic [63:0] sext14(input logic [13:0] imm);
      return {{50{imm[13]}}, imm};
   endfunction

   function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] flags);
      logic taken;
      case (cc)
         CC_EQ:   taken = flags[FLAG_Z];
         CC_NE:   taken = ~flags[FLAG_Z];
         CC_LT:   taken = flags[FLAG_N] ^ flags[FLAG_V];
         CC_GE:   taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
         CC_CS:   taken = flags[FLAG_C];
         CC_CC:   taken = ~flags[FLAG_C];
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational control-word decode from IR and sequencer state
module cu_decoder
   import cu_pkg::*;
(
   input  logic [31:0] ir_i,
   input  state_t      state_i,
   output logic [4:0]  da_o,
   output logic [4:0]  sa_o,
   output logic [4:0]  sb_o,
   output logic [63:0] k_o,
   output logic        bs_o,
   output logic [4:0]  fs_o,
   output logic        reg_w_o,
   output logic        ram_w_o,
   output logic        sel_en_o
);

   op_e op;
   assign op = op_e'(ir_i[OP_MSB:OP_LSB]);

   always_comb begin
      da_o     = ir_i[DA_MSB:DA_LSB];
      sa_o     = ir_i[SA_MSB:SA_LSB];
      sb_o     = ir_i[SB_MSB:SB_LSB];
      k_o      = sext14(ir_i[IMM_MSB:IMM_LSB]);
      bs_o     = 1'b0;
      fs_o     = ir_i[FS_MSB:FS_LSB];
      reg_w_o  = 1'b0;
      ram_w_o  = 1'b0;
      sel_en_o = 1'b1;
      case (op)
         OP_ALU_R: reg_w_o = (state_i == ST_EXEC);
         OP_ALU_I: begin
            bs_o    = 1'b1;
            reg_w_o = (state_i == ST_EXEC);
         end
         OP_LOAD: begin
            bs_o     = 1'b1;
            fs_o     = FS_ADD;
            sel_en_o = 1'b0;
            reg_w_o  = (state_i == ST_MEM);
         end
         OP_STORE: begin
            // Store data comes from the register named in the DA field
            bs_o    = 1'b1;
            fs_o    = FS_ADD;
            sb_o    = ir_i[DA_MSB:DA_LSB];
            ram_w_o = (state_i == ST_EXEC);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - FETCH/EXEC/MEM/HALT sequencer with pc, IR and flags
// Define CU_COND_BRANCH_EN to build the flag register and conditional branches.
module control_sequencer
   import cu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [3:0]  status,
   output logic [15:0] pc,
   output logic [4:0]  DA,
   output logic [4:0]  SA,
   output logic [4:0]  SB,
   output logic [63:0] K,
   output logic        BS,
   output logic [4:0]  FS,
   output logic        regW,
   output logic        ramW,
   output logic        selEN,
   output logic        halted
);

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        dec_reg_w, dec_ram_w;
   logic        branch_taken;
   logic [15:0] pc_inc, pc_target;
   op_e         op;

   assign op        = op_e'(ir_q[OP_MSB:OP_LSB]);
   assign pc_inc    = pc_q + 16'd1;
   assign pc_target = pc_q + K[15:0];

   cu_decoder u_decoder (
      .ir_i     (ir_q),
      .state_i  (state_q),
      .da_o     (DA),
      .sa_o     (SA),
      .sb_o     (SB),
      .k_o      (K),
      .bs_o     (BS),
      .fs_o     (FS),
      .reg_w_o  (dec_reg_w),
      .ram_w_o  (dec_ram_w),
      .sel_en_o (selEN)
   );

`ifdef CU_COND_BRANCH_EN
   logic [3:0] flags_q, flags_d;

   assign branch_taken = (op == OP_B) ||
                         ((op == OP_BCOND) && cond_holds(ir_q[CC_MSB:CC_LSB], flags_q));

   always_comb begin
      flags_d = flags_q;
      if ((state_q == ST_EXEC) && ((op == OP_ALU_R) || (op == OP_ALU_I)))
         flags_d = status;
   end

   always_ff @(posedge clock) begin
      if (reset) flags_q <= 4'd0;
      else       flags_q <= flags_d;
   end
`else
   logic unused_status;
   assign unused_status = ^status;
   assign branch_taken  = (op == OP_B);
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         ST_FETCH: begin
            ir_d    = instr;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            case (op)
               OP_LOAD: state_d = ST_MEM;
               OP_HALT: state_d = ST_HALT;
               default: begin
                  state_d = ST_FETCH;
                  pc_d    = branch_taken ? pc_target : pc_inc;
               end
            endcase
         end
         ST_MEM: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= 16'd0;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Reset aborts the instruction, so no write may escape in the reset cycle
   assign regW   = dec_reg_w & ~reset;
   assign ramW   = dec_ram_w & ~reset;
   assign halted = (state_q == ST_HALT);
   assign pc     = pc_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized checks against an instruction-level model
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [3:0]  status;
   logic [15:0] pc;
   logic [4:0]  DA, SA, SB, FS;
   logic [63:0] K;
   logic        BS, regW, ramW, selEN, halted;

   logic [31:0] imem [0:65535];

   int n_checks = 0;
   int n_errors = 0;
   int mpc;
   logic [3:0] mflags;

   assign instr = imem[pc];

   always #5 clock = ~clock;

   control_sequencer dut (
      .clock  (clock),
      .reset  (reset),
      .instr  (instr),
      .status (status),
      .pc     (pc),
      .DA     (DA),
      .SA     (SA),
      .SB     (SB),
      .K      (K),
      .BS     (BS),
      .FS     (FS),
      .regW   (regW),
      .ramW   (ramW),
      .selEN  (selEN),
      .halted (halted)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] fs,
                                       input logic [4:0] da, input logic [4:0] sa,
                                       input logic [13:0] imm);
      return {op, fs, da, sa, imm};
   endfunction

   function automatic longint sext_model(input int imm14);
      return (imm14 >= 8192) ? longint'(imm14 - 16384) : longint'(imm14);
   endfunction

   function automatic bit cond_model(input int cc, input logic [3:0] f);
      bit z, n, c, v;
      z = f[0]; n = f[1]; c = f[2]; v = f[3];
      case (cc)
         0: return z;
         1: return !z;
         2: return n != v;
         3: return n == v;
         4: return c;
         5: return !c;
         default: return 1'b0;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mpc = 0;
      mflags = 4'd0;
   endtask

   // Runs one instruction from FETCH through its last state; st_force < 0 means random status
   task automatic exec_instr(input logic [31:0] w, input int st_force);
      int op, fs, da, sa, sb, imm, cc;
      longint k;
      logic [3:0] st;
      op  = int'(w[31:29]);
      fs  = int'(w[28:24]);
      da  = int'(w[23:19]);
      sa  = int'(w[18:14]);
      sb  = int'(w[13:9]);
      imm = int'(w[13:0]);
      cc  = int'(w[22:19]);
      k   = sext_model(imm);
      imem[mpc] = w;
      status = 4'($urandom_range(0, 15));
      chk("fetch_pc", pc, mpc);
      chk("fetch_regW", regW, 0);
      chk("fetch_ramW", ramW, 0);
      chk("fetch_halted", halted, 0);
      tick();
      st = (st_force < 0) ? 4'($urandom_range(0, 15)) : 4'(st_force);
      status = st;
      #1;
      chk("exec_pc", pc, mpc);
      chk("exec_halted", halted, 0);
      case (op)
         0: begin
            chk("aluR_BS", BS, 0); chk("aluR_regW", regW, 1); chk("aluR_ramW", ramW, 0);
            chk("aluR_selEN", selEN, 1); chk("aluR_FS", FS, fs); chk("aluR_DA", DA, da);
            chk("aluR_SA", SA, sa); chk("aluR_SB", SB, sb);
         end
         1: begin
            chk("aluI_BS", BS, 1); chk("aluI_K", K, k); chk("aluI_regW", regW, 1);
            chk("aluI_ramW", ramW, 0); chk("aluI_selEN", selEN, 1); chk("aluI_DA", DA, da);
         end
         2: begin
            chk("ldE_BS", BS, 1); chk("ldE_K", K, k); chk("ldE_FS", FS, 8);
            chk("ldE_selEN", selEN, 0); chk("ldE_regW", regW, 0); chk("ldE_ramW", ramW, 0);
         end
         3: begin
            chk("st_BS", BS, 1); chk("st_K", K, k); chk("st_FS", FS, 8);
            chk("st_ramW", ramW, 1); chk("st_regW", regW, 0); chk("st_SB", SB, da);
         end
         default: begin
            chk("nowr_regW", regW, 0); chk("nowr_ramW", ramW, 0);
         end
      endcase
      tick();
      if (op == 2) begin
         chk("ldM_pc", pc, mpc); chk("ldM_regW", regW, 1); chk("ldM_ramW", ramW, 0);
         chk("ldM_selEN", selEN, 0); chk("ldM_FS", FS, 8); chk("ldM_BS", BS, 1);
         chk("ldM_K", K, k); chk("ldM_DA", DA, da);
         tick();
      end
      case (op)
         4: mpc = (mpc + int'(k)) & 32'hFFFF;
`ifdef CU_COND_BRANCH_EN
         5: mpc = cond_model(cc, mflags) ? ((mpc + int'(k)) & 32'hFFFF) : ((mpc + 1) & 32'hFFFF);
`endif
         7: begin
            chk("halt_halted", halted, 1);
            chk("halt_pc", pc, mpc);
         end
         default: mpc = (mpc + 1) & 32'hFFFF;
      endcase
`ifdef CU_COND_BRANCH_EN
      if (op == 0 || op == 1) mflags = st;
`endif
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 65536; i++) imem[i] = {3'd6, 29'd0};
      reset  = 1'b1;
      status = 4'd0;
      mpc    = 0;
      mflags = 4'd0;
      tick();
      tick();
      chk("rst_pc", pc, 0);
      chk("rst_regW", regW, 0);
      chk("rst_ramW", ramW, 0);
      chk("rst_halted", halted, 0);
      chk("rst_K", K, 0);
      chk("rst_BS", BS, 0);
      chk("rst_FS", FS, 0);
      chk("rst_selEN", selEN, 1);
      chk("rst_DA", DA, 0);
      reset = 1'b0;

      exec_instr(enc(3'd1, 5'd3, 5'd1, 5'd0, 14'h3FFF), -1);
      chk("aluI_pc_after", pc, 1);
      exec_instr(enc(3'd2, 5'd0, 5'd2, 5'd1, 14'd4), -1);
      chk("load_pc_after", pc, 2);

      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         for (int i = 0; i < 4; i++) exec_instr(enc(3'd6, 5'd0, 5'd0, 5'd0, 14'd0), -1);
         exec_instr(enc(3'd0, 5'd2, 5'd3, 5'd4, 14'd0), (pass == 0) ? 1 : 0);
         chk("bcond_at5", mpc, 5);
         exec_instr(enc(3'd5, 5'd0, 5'd0, 5'd0, 14'h3FFE), -1);
`ifdef CU_COND_BRANCH_EN
         chk("bcond_eq_pc", pc, (pass == 0) ? 3 : 6);
`else
         chk("bcond_nop_pc", pc, 6);
`endif
      end

      do_reset();
      exec_instr(enc(3'd4, 5'd0, 5'd0, 5'd0, 14'h3FFF), -1);
      chk("b_wrap_down", pc, 16'hFFFF);
      exec_instr(enc(3'd4, 5'd0, 5'd0, 5'd0, 14'd1), -1);
      chk("b_wrap_up", pc, 0);
      exec_instr(enc(3'd3, 5'd5, 5'd7, 5'd2, 14'h1234), -1);
      chk("store_ramW_once", ramW, 0);

      do_reset();
      for (int n = 0; n < 300; n++) begin
         w = $urandom;
         w[31:29] = 3'($urandom_range(0, 6));
         exec_instr(w, -1);
      end

      do_reset();
      for (int i = 0; i < 9; i++) exec_instr(enc(3'd6, 5'd0, 5'd0, 5'd0, 14'd0), -1);
      exec_instr(enc(3'd7, 5'd0, 5'd1, 5'd1, 14'd0), -1);
      for (int i = 0; i < 20; i++) begin
         chk("halt_hold_halted", halted, 1);
         chk("halt_hold_pc", pc, 9);
         chk("halt_hold_regW", regW, 0);
         chk("halt_hold_ramW", ramW, 0);
         tick();
      end
      do_reset();
      chk("halt_rst_pc", pc, 0);
      chk("halt_rst_halted", halted, 0);

      imem[0] = enc(3'd2, 5'd0, 5'd2, 5'd1, 14'd4);
      tick();
      tick();
      chk("mem_pre_regW", regW, 1);
      reset = 1'b1;
      #1;
      chk("mem_rst_regW", regW, 0);
      chk("mem_rst_ramW", ramW, 0);
      tick();
      reset = 1'b0;
      mpc = 0;
      mflags = 4'd0;
      chk("mem_rst_pc", pc, 0);
      exec_instr(enc(3'd3, 5'd0, 5'd4, 5'd1, 14'd8), -1);

      do_reset();
      imem[0] = enc(3'd3, 5'd0, 5'd4, 5'd1, 14'd8);
      tick();
      chk("st_pre_ramW", ramW, 1);
      reset = 1'b1;
      #1;
      chk("st_rst_ramW", ramW, 0);
      tick();
      reset = 1'b0;
      mpc = 0;
      mflags = 4'd0;
      exec_instr(enc(3'd1, 5'd1, 5'd2, 5'd3, 14'd5), -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port instr, input, 32, instruction word read combinationally at address pc.
REQ-004 SHALL have port status, input, 4, datapath ALU flags {V,C,N,Z} = [3:0], with Z in bit 0.
REQ-005 SHALL have port pc, output, 16, word address of the current instruction.
REQ-006 SHALL have ports DA, SA, SB, output, 5 each, destination and source register selects.
REQ-007 SHALL have port K, output, 64, sign-extended immediate.
REQ-008 SHALL have ports BS, output, 1 (1 selects K as ALU B operand), and FS, output, 5, ALU function select.
REQ-009 SHALL have ports regW, ramW, selEN, output, 1 each: register write, RAM write, and data select (1 = ALU, 0 = RAM).
REQ-010 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-011 SHALL latch instr into IR at the end of FETCH; fields: op = IR[31:29], FS = IR[28:24], DA = IR[23:19], SA = IR[18:14], SB = IR[13:9], imm14 = IR[13:0].
REQ-012 SHALL implement states FETCH, EXEC, MEM, HALT; transitions: FETCH->EXEC always; EXEC->MEM for LOAD; EXEC->HALT for op 7; EXEC->FETCH otherwise; MEM->FETCH; HALT->HALT.
REQ-013 SHALL drive regW = 0 and ramW = 0 in FETCH and HALT; all write enables are asserted for exactly one cycle per instruction.
REQ-014 op 0 (ALU_R): in EXEC drive BS = 0, regW = 1, selEN = 1, and FS from IR.
REQ-015 op 1 (ALU_I): in EXEC drive BS = 1, K = sext(imm14), regW = 1, selEN = 1.
REQ-016 op 2 (LOAD): in EXEC and MEM drive BS = 1, K = sext(imm14), FS = FS_ADD, selEN = 0; regW = 1 only in MEM; total 3 cycles.
REQ-017 op 3 (STORE): in EXEC drive BS = 1, K = sext(imm14), FS = FS_ADD, ramW = 1, regW = 0, and SB = IR[23:19] (data source).
REQ-018 op 4 (B): in EXEC set next pc = pc + sext(imm14)[15:0], with modulo-2^16 wrap.
REQ-019 op 5 (B.cond): cond = IR[22:19]; EQ = 0 (Z), NE = 1 (!Z), LT = 2 (N^V), GE = 3 (!(N^V)), CS = 4 (C), CC = 5 (!C); codes 6-15 are never taken; taken -> pc + sext(imm14), else pc + 1.
REQ-020 SHALL update the flag register from status at the end of EXEC for ops 0 and 1 only; B.cond tests the flag register, never the live status input.
REQ-021 op 6 is reserved and SHALL execute as a NOP: no writes, next pc = pc + 1.
REQ-022 op 7 (HALT): no writes; pc stays at the HALT address; halted = 1 from the next cycle.
REQ-023 pc SHALL be stable for the whole instruction and update only at the end of its final state; the default is pc + 1 with wrap from 16'hFFFF to 0.
REQ-024 Cycle counts SHALL be 2 for ops 0, 1, 3, 4, 5, 6; 3 for LOAD.

Reset
REQ-025 Reset SHALL set pc = 0, state = FETCH, IR = 0, flags = 0, halted = 0, regW = ramW = 0; all other outputs are decoded from IR = 0.
REQ-026 Reset asserted in any state, including mid-LOAD or HALT, SHALL abort the instruction with no write in the reset cycle, and FETCH of address 0 SHALL follow.

Configuration
REQ-027 Macro CU_COND_BRANCH_EN defined: flag register and op 5 behave per REQ-019/020.
REQ-028 Macro CU_COND_BRANCH_EN undefined: no flag register is built, and op 5 SHALL execute as a NOP per REQ-021.

Structure
REQ-029 Package cu_pkg SHALL hold the opcode enum, state enum, condition-code constants, FS_ADD = 5'b01000, and field position constants.
REQ-030 One combinational sub-module, cu_decoder (IR and state in, control word out), SHALL be instantiated; sequencing, pc, and flags stay in control_sequencer.

Verification
REQ-031 Reset, then ALU_I DA = 1, imm14 = 14'h3FFF -> EXEC cycle shows K = 64'hFFFF_FFFF_FFFF_FFFF, BS = 1, regW = 1; pc goes 0 -> 1 after 2 cycles.
REQ-032 LOAD DA = 2, SA = 1, imm = 4 -> EXEC regW = 0, MEM regW = 1, selEN = 0, FS = 01000; pc advances after 3 cycles.
REQ-033 ALU_R with status = 4'b0001, then B.cond EQ imm = -2 at pc = 5 -> pc = 3; same sequence with status = 0 -> pc = 6.
REQ-034 B imm = 1 at pc = 16'hFFFF -> pc = 0 (wrap); STORE -> ramW = 1 for exactly one cycle and SB = IR[23:19].
REQ-035 HALT at pc = 9 -> halted = 1, pc = 9, no writes for 20 cycles; reset -> pc = 0, halted = 0.
REQ-036 Reset asserted during MEM of a LOAD -> regW = 0 in that cycle, then FETCH at pc = 0; with CU_COND_BRANCH_EN undefined, B.cond -> pc + 1.
